// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC iteration sequencer.
package cordic_pkg;
   localparam int K_WIDTH         = 5;
   localparam int ANGLE_MAX       = 99;
   localparam int ANGLE_DEPTH_DEF = 10;

   typedef logic signed [ANGLE_DEPTH_DEF-1:0] angle_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } state_t;
endpackage

// File: rtl/cordic_seq_ctrl.sv
// CORDIC iteration sequencer: walks k through the atan LUT, accumulates the residual z.
// Optional early termination on a zero residual is enabled by defining CORDIC_EARLY_TERM_EN.
module cordic_seq_ctrl
   import cordic_pkg::*;
#(
   parameter int ITERATIONS  = 20,
   parameter int ANGLE_DEPTH = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [ANGLE_DEPTH-1:0] angle_in,
   output logic [K_WIDTH-1:0]            lut_k,
   input  logic signed [ANGLE_DEPTH-1:0] lut_angle,
   output logic                          xy_load,
   output logic                          xy_step,
   output logic                          xy_dir,
   output logic                          busy,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [ANGLE_DEPTH-1:0] z_res
);

`ifdef CORDIC_EARLY_TERM_EN
   localparam bit EARLY_TERM = 1'b1;
`else
   localparam bit EARLY_TERM = 1'b0;
`endif

   localparam logic [K_WIDTH-1:0]            K_LAST = K_WIDTH'(ITERATIONS - 1);
   localparam logic signed [ANGLE_DEPTH-1:0] Z_HI   = ANGLE_DEPTH'(ANGLE_MAX);
   localparam logic signed [ANGLE_DEPTH-1:0] Z_LO   = -Z_HI;

   state_t                          state_q;
   logic [K_WIDTH-1:0]              k_q;
   logic signed [ANGLE_DEPTH-1:0]   z_q;
   logic signed [ANGLE_DEPTH-1:0]   z_res_q;
   logic                            in_ready_q;
   logic                            xy_load_q;
   logic                            xy_step_q;
   logic                            busy_q;
   logic                            out_valid_q;

   logic                            dir;
   logic                            stop_early;
   logic signed [ANGLE_DEPTH-1:0]   z_step_d;
   logic signed [ANGLE_DEPTH-1:0]   z_clamp_d;

   assign dir        = ~z_q[ANGLE_DEPTH-1];
   assign z_step_d   = dir ? (z_q - lut_angle) : (z_q + lut_angle);
   assign stop_early = EARLY_TERM && (k_q != '0) && (z_q == '0);

   // The clamp keeps |z| within the LUT sum so the residual never wraps.
   always_comb begin
      z_clamp_d = angle_in;
      if (angle_in > Z_HI) begin
         z_clamp_d = Z_HI;
      end else if (angle_in < Z_LO) begin
         z_clamp_d = Z_LO;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         k_q         <= '0;
         z_q         <= '0;
         z_res_q     <= '0;
         in_ready_q  <= 1'b1;
         xy_load_q   <= 1'b0;
         xy_step_q   <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  state_q    <= LOAD;
                  z_q        <= z_clamp_d;
                  k_q        <= '0;
                  in_ready_q <= 1'b0;
                  xy_load_q  <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            LOAD: begin
               state_q   <= ITER;
               xy_load_q <= 1'b0;
               xy_step_q <= 1'b1;
            end
            ITER: begin
               if (stop_early) begin
                  state_q     <= DONE;
                  k_q         <= '0;
                  z_q         <= '0;
                  z_res_q     <= '0;
                  xy_step_q   <= 1'b0;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end else if (k_q == K_LAST) begin
                  state_q     <= DONE;
                  k_q         <= '0;
                  z_q         <= z_step_d;
                  z_res_q     <= z_step_d;
                  xy_step_q   <= 1'b0;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end else begin
                  k_q       <= k_q + K_WIDTH'(1);
                  z_q       <= z_step_d;
                  // Look ahead: a zero residual next cycle means that cycle issues no step.
                  xy_step_q <= !(EARLY_TERM && (z_step_d == '0));
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign lut_k     = k_q;
   assign xy_load   = xy_load_q;
   assign xy_step   = xy_step_q;
   assign xy_dir    = dir;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign z_res     = z_res_q;

endmodule

// File: doc/cordic_seq_ctrl.md
Name: cordic_seq_ctrl

Overview:
- Iteration sequencer for the iterative CORDIC rotation engine.
- Accepts a target angle in whole degrees over a valid/ready handshake and walks the iteration index k = 0..ITERATIONS-1 into the arctangent LUT.
- Accumulates the residual angle z and emits per-iteration load, step and direction controls to the x/y shift-add datapath.
- Presents the final residual on a valid/ready output.

Parameters:
- ITERATIONS, 20, number of CORDIC micro-rotations per operation; legal range 1..32 (k is 5 bits).
- ANGLE_DEPTH, 10, width of angle and residual words (two's complement, degrees).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  angle_in is valid
- in_ready  out  1  controller can accept an angle
- angle_in  in  ANGLE_DEPTH  signed target angle, degrees
- lut_k  out  5  iteration index to the arctangent LUT
- lut_angle  in  ANGLE_DEPTH  atan(2^-k) in degrees, combinational from the LUT
- xy_load  out  1  one-cycle pulse: datapath loads its initial x/y
- xy_step  out  1  datapath performs one micro-rotation this cycle
- xy_dir  out  1  1 = rotate positive (z >= 0), 0 = negative
- busy  out  1  operation in progress (LOAD or ITER)
- out_valid  out  1  z_res is valid
- out_ready  in  1  downstream accepts the result
- z_res  out  ANGLE_DEPTH  signed final residual angle

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, k=0, z=0, out_valid=0, xy_load=0, xy_step=0, busy=0, z_res=0; in_ready is 1 in the first cycle after reset.
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE: in_ready=1. On in_valid & in_ready:
  - z <= clamp(angle_in, -99, +99), where 99 is the LUT sum for k=0..6.
  - k <= 0; next state LOAD.
- LOAD (exactly one cycle): xy_load=1, busy=1, in_ready=0; next state ITER.
- ITER: xy_step=1, busy=1; lut_k=k; xy_dir = ~z[MSB].
  - If xy_dir=1: z <= z - lut_angle; otherwise z <= z + lut_angle. Arithmetic is ANGLE_DEPTH-bit; the clamp guarantees no wrap.
  - k increments each cycle. In the cycle with k == ITERATIONS-1, the step is still performed and the next state is DONE.
- DONE: out_valid=1, z_res=z held stable; in_ready=0. On out_ready, next state IDLE. Backpressure holds DONE indefinitely.
- Latency: acceptance edge T gives LOAD in cycle T+1, ITER in T+2..T+1+ITERATIONS, and out_valid from T+2+ITERATIONS. No pipelining: one operation in flight; a new accept is possible the cycle after the out handshake.
- lut_k equals the k register in every state; it is 0 outside ITER.
- in_valid while not in IDLE is ignored (in_ready=0). out_ready outside DONE is ignored.
- Reset mid-operation: the next cycle is IDLE, with no out_valid and no partial result; the datapath sees no further step pulses.

Optional Feature:
- Macro: CORDIC_EARLY_TERM_EN.
- Defined: in ITER, when k > 0 and z == 0 at the start of the cycle, no step is issued (xy_step=0) and the next state is DONE with z_res = 0. This saves cycles once the remaining table entries are 0.
- Undefined: always exactly ITERATIONS step cycles.

Decomposition:
- Shared package cordic_pkg holds:
  - the state enum (IDLE, LOAD, ITER, DONE);
  - the constant K_WIDTH = 5;
  - the ANGLE_MAX = 99 clamp constant;
  - the angle typedef sized by ANGLE_DEPTH.
- No sub-module: the LUT is instantiated alongside, not inside, this block.

Test Plan:
- angle_in=30, out_ready=1 -> xy_dir for k0..6 = 1,0,1,0,1,1,0 and 0 for k7..19; 20 xy_step cycles; z_res=-1; out_valid 22 cycles after accept.
- angle_in=0 -> xy_dir for k0..6 = 1,0,0,0,1,0,1 and 0 thereafter; z_res=-1. With CORDIC_EARLY_TERM_EN: done after 6 steps (k0..5), z_res=0.
- angle_in=150 (clamped to 99) -> xy_dir=1 on all steps; z reaches 0 after k=6; z_res=0. With CORDIC_EARLY_TERM_EN: 7 steps, z_res=0.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and z_res stable, in_ready=0, a second in_valid is not accepted; accepted on the cycle after out_ready=1.
- Assert rst while in ITER at k=10 -> next cycle: IDLE, in_ready=1, busy=0, out_valid=0, lut_k=0. A new angle_in=-45 then completes with xy_dir k0=0 and z_res correct.
- Back-to-back: in_valid held high with angle_in=45 -> the second accept occurs the cycle after the first out handshake; xy_load pulses once per operation.
